// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bundle.
// sub/ovf exist only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  modport master (
    output start, a, b, ci,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
    input  ovf,
`endif
    input  s, co, busy, done
  );

  modport slave (
    input  start, a, b, ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
    output ovf,
`endif
    output s, co, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, BITS_PER_CYCLE bits per clock.
// Optional subtract/overflow via SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             done_q;
  logic             load, step, last;

  logic [BPC:0]         slice;
  logic [WIDTH+BPC-1:0] r_cat;
  logic [WIDTH-1:0]     r_next;
  logic [WIDTH-1:0]     b_in;
  logic                 ci_in;

  assign slice = {1'b0, a_sr[BPC-1:0]}
               + {1'b0, b_sr[BPC-1:0]}
               + (BPC+1)'(cy);
  // New slice enters at the MSB end.
  assign r_cat  = {slice[BPC-1:0], r_sr};
  assign r_next = r_cat[WIDTH+BPC-1:BPC];
  assign last   = (cnt == CW'(STEPS - 1));

`ifdef SERIAL_ADDER_SUB_EN
  logic ovf_q;
  logic c_msb;
  // Carry into the MSB recovered from the top slice bit.
  assign c_msb = a_sr[BPC-1] ^ b_sr[BPC-1]
               ^ slice[BPC-1];
  assign b_in  = bus.sub ? ~bus.b : bus.b;
  assign ci_in = bus.sub ? 1'b1 : bus.ci;
  assign bus.ovf = ovf_q;
`else
  assign b_in  = bus.b;
  assign ci_in = bus.ci;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      co_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= step && last;
      if (load) begin
        a_sr <= bus.a;
        b_sr <= b_in;
        cy   <= ci_in;
        cnt  <= '0;
      end else if (step) begin
        a_sr <= a_sr >> BPC;
        b_sr <= b_sr >> BPC;
        r_sr <= r_next;
        cy   <= slice[BPC];
        cnt  <= cnt + CW'(1);
        if (last) begin
          s_q  <= r_next;
          co_q <= slice[BPC];
        end
      end
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (load) sub_q <= bus.sub;
      if (step && last) ovf_q <= c_msb ^ slice[BPC];
    end
  end
`endif

  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q == RUN);
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in, processing BITS_PER_CYCLE bits per clock through one shared adder slice.
- Successor to the combinational half adder. With ci=0 it computes the same function (sum/carry), generalised in width.
- Adds a start/busy/done handshake and a registered result.
- Used where area matters more than latency, e.g. serial datapaths and accumulators.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- BITS_PER_CYCLE, 1, bits processed per clock; must be at least 1 and divide WIDTH exactly.
- STEPS (localparam), WIDTH/BITS_PER_CYCLE, number of processing cycles per operation.

Ports:
- clk  in  1  clock; all flops capture on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- ci  in  1  carry-in; latched when start is accepted.
- s  out  WIDTH  registered sum; holds the last result.
- co  out  1  registered carry-out; holds the last result.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse marking a new valid s/co.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - s=0, co=0, busy=0, done=0.
  - Operand shift registers, carry flop and step counter are cleared.
  - Reset asserted mid-operation aborts it: no done pulse, s/co read 0.
- State machine has two states, IDLE and RUN.
- IDLE:
  - busy=0.
  - If start=1 at edge E0: latch a, b and ci; clear the counter; go to RUN. busy reads 1 after E0.
- RUN, at each edge E1..E(STEPS):
  - Add the BITS_PER_CYCLE LSBs of the A and B shift registers plus the carry flop.
  - Shift the partial-sum slice into the result shift register from the MSB end.
  - Shift the operand registers right by BITS_PER_CYCLE.
  - Update the carry flop with the slice carry-out.
  - Increment the counter.
- Completion, at edge E(STEPS):
  - s <= full result shift register; co <= final slice carry.
  - done <= 1, busy <= 0, state goes to IDLE.
  - done returns to 0 at E(STEPS+1).
- Latency and throughput:
  - busy is high for exactly STEPS cycles; done is high for exactly 1 cycle.
  - A new start is accepted at E(STEPS+1) at the earliest, giving a throughput of one operation per STEPS+1 cycles.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(WIDTH+1). No saturation.
- s and co do not change during RUN; they keep the previous result until the completion edge.
- start while busy=1 (including at edge E(STEPS)) is ignored and not queued. Operand changes during RUN have no effect.
- start held high continuously gives back-to-back operations, one per STEPS+1 cycles, using a/b/ci as sampled at each accepting edge.
- BITS_PER_CYCLE=WIDTH: STEPS=1, so busy lasts 1 cycle and done follows on the next edge.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), latched with the operands at start.
  - Extra output port ovf (1 bit), registered; resets to 0; updates on the completion edge alongside s/co.
  - sub=1: compute a + ~b + 1 and ignore ci. co=1 means no borrow.
  - ovf = signed two's-complement overflow of the operation (add or subtract), i.e. the carry into the MSB XOR the carry out of the MSB.
  - sub=0: behaviour is identical to the undefined case.
- Undefined: no sub or ovf ports; addition only.

Test Plan:
- WIDTH=8, BPC=1; start with a=8'hFF, b=8'h01, ci=0 -> busy high 8 cycles, then done pulse 1 cycle; s=8'h00, co=1.
- a=8'h5A, b=8'h33, ci=1 -> s=8'h8E, co=0. s holds the previous result (8'h00) throughout RUN.
- Start with a=8'h01, b=8'h01, then start held with a=8'hF0 while busy -> result s=8'h02, co=0. Second operation begins only at E9, giving s=8'hF0+b as sampled then.
- Drop rst_n at E4 of an operation -> s=0, co=0, busy=0 immediately; no done pulse; next start runs a full 8 cycles.
- WIDTH=8, BPC=4; a=8'hA7, b=8'h6C, ci=0 -> busy 2 cycles, done at E2, s=8'h13, co=1.
- SERIAL_ADDER_SUB_EN defined:
  - 8'h10 - 8'h20 -> s=8'hF0, co=0, ovf=0.
  - 8'h80 - 8'h01 -> s=8'h7F, co=1, ovf=1.
